// File: rtl/uart_pkg.sv
// Shared definitions for the UART link: frame format, idle level,
// receiver state encoding and baud divisor helper.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous inputs (serial line, switches),
// with a selectable value loaded on reset.
module uart_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_sig,
  output logic sync_sig
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= RESET_VAL;
      sync_sig <= RESET_VAL;
    end else begin
      meta     <= async_sig;
      sync_sig <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling of start, data and stop bits,
// one-cycle data_valid / frame_err pulses, break-safe after a bad stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $fatal(1, "uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic                 rx_s;
  uart_state_t          state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  uart_sync #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .async_sig (rx),
    .sync_sig  (rx_s)
  );

  // Every transition clears clk_cnt so each state times from zero;
  // busy is registered alongside the state so it tracks "not IDLE".
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (rx_s != IDLE_LEVEL) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (rx_s != IDLE_LEVEL) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt            <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx_s == IDLE_LEVEL) begin
              data       <= shift_reg;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not be mistaken for a new start bit.
          clk_cnt <= '0;
          if (rx_s == IDLE_LEVEL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a fast-baud instance for the functional
// cases and a default-parameter instance for the absolute timing check.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rx_def;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] data_def;
  logic       data_valid_def;
  logic       frame_err_def;
  logic       busy_def;

  int cyc;
  int vectors;
  int miscompares;

  typedef struct {
    logic [7:0] data;
    bit         is_err;
    int         cyc;
  } exp_t;

  exp_t q_main[$];
  exp_t q_def[$];

  logic [7:0] last_good;
  logic [7:0] last_good_def;

  uart_rx #(
    .CLK_FREQ  (160),
    .BAUD_RATE (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  uart_rx #(
    .CLK_FREQ  (50000000),
    .BAUD_RATE (9600)
  ) dut_def (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx_def),
    .data       (data_def),
    .data_valid (data_valid_def),
    .frame_err  (frame_err_def),
    .busy       (busy_def)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Must be called at a falling edge; drives one full 10-bit frame.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_lvl, input int bclk,
                               input bit on_def, input bit expect_it);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop_lvl, b, 1'b0};
    if (expect_it) begin
      e.is_err = ~stop_lvl;
      e.cyc    = cyc + 1 + 2 + bclk / 2 + 9 * bclk;
      if (on_def) begin
        e.data = stop_lvl ? b : last_good_def;
        if (stop_lvl) last_good_def = b;
        q_def.push_back(e);
      end else begin
        e.data = stop_lvl ? b : last_good;
        if (stop_lvl) last_good = b;
        q_main.push_back(e);
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (on_def) rx_def = bits[i];
      else        rx     = bits[i];
      repeat (bclk) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (data_valid || frame_err)) begin
      if (q_main.size() == 0) begin
        checkOutput("unexpected pulse", {30'd0, data_valid, frame_err}, 32'd0);
      end else begin
        e = q_main.pop_front();
        checkOutput("pulse kind", {30'd0, data_valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
        checkOutput("pulse data", {24'd0, data}, {24'd0, e.data});
        checkOutput("pulse cycle", cyc, e.cyc);
      end
    end
    if (!reset && (data_valid_def || frame_err_def)) begin
      if (q_def.size() == 0) begin
        checkOutput("unexpected pulse def", {30'd0, data_valid_def, frame_err_def}, 32'd0);
      end else begin
        e = q_def.pop_front();
        checkOutput("pulse kind def", {30'd0, data_valid_def, frame_err_def}, e.is_err ? 32'd1 : 32'd2);
        checkOutput("pulse data def", {24'd0, data_def}, {24'd0, e.data});
        checkOutput("pulse cycle def", cyc, e.cyc);
      end
    end
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    last_good     = 8'h00;
    last_good_def = 8'h00;
    rx            = 1'b1;
    rx_def        = 1'b1;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset data", {24'd0, data}, 32'd0);
    checkOutput("reset valid", {31'd0, data_valid}, 32'd0);
    checkOutput("reset ferr", {31'd0, frame_err}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset busy def", {31'd0, busy_def}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] single frame 0xA5");
    fork
      applyStimulus(8'hA5, 1'b1, 16, 1'b0, 1'b1);
      begin
        repeat (2) @(negedge clk);
        checkOutput("busy before start", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("busy at start", {31'd0, busy}, 32'd1);
      end
    join
    repeat (20) @(negedge clk);
    checkOutput("data held A5", {24'd0, data}, 32'hA5);
    checkOutput("busy idle A5", {31'd0, busy}, 32'd0);

    $display("[TB] back-to-back 0x00 0xFF 0x55");
    applyStimulus(8'h00, 1'b1, 16, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b1, 16, 1'b0, 1'b1);
    applyStimulus(8'h55, 1'b1, 16, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("data held 55", {24'd0, data}, 32'h55);

    $display("[TB] glitch rejection");
    rx = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 5) rx = 1'b1;
      if (j == 2 || j == 11) checkOutput("glitch busy low", {31'd0, busy}, 32'd0);
      if (j == 3 || j == 10) checkOutput("glitch busy high", {31'd0, busy}, 32'd1);
    end
    checkOutput("glitch data kept", {24'd0, data}, 32'h55);

    $display("[TB] framing error 0x3C");
    applyStimulus(8'h3C, 1'b0, 16, 1'b0, 1'b1);
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      if (j % 16 == 0) checkOutput("break busy", {31'd0, busy}, 32'd1);
    end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("busy before rise seen", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("busy after rise", {31'd0, busy}, 32'd0);
    checkOutput("ferr data kept", {24'd0, data}, 32'h55);
    repeat (10) @(negedge clk);

    $display("[TB] reset during data bit 4 of 0x81");
    checkOutput("queue drained", q_main.size(), 32'd0);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0) ? 1'b1 : 1'b0;
      repeat (16) @(negedge clk);
    end
    rx = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_good = 8'h00;
    checkOutput("mid reset data", {24'd0, data}, 32'd0);
    checkOutput("mid reset valid", {31'd0, data_valid}, 32'd0);
    checkOutput("mid reset ferr", {31'd0, frame_err}, 32'd0);
    checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
    repeat (200) @(negedge clk);
    checkOutput("after reset data", {24'd0, data}, 32'd0);
    applyStimulus(8'h81, 1'b1, 16, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("data held 81", {24'd0, data}, 32'h81);

    $display("[TB] default parameters 0x01");
    applyStimulus(8'h01, 1'b1, 5208, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("data held def", {24'd0, data_def}, 32'h01);

    checkOutput("missing pulses", q_main.size(), 32'd0);
    checkOutput("missing pulses def", q_def.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the switch-to-LED link between the two boards: it consumes the asynchronous `rx` line driven by the partner board's transmitter and produces the received byte that drives the local LEDs. It synchronises the line, validates the start bit at mid-bit, samples 8 data bits LSB-first, checks the stop bit, and reports each frame as a one-cycle valid or framing-error pulse. The 8N1 frame format and baud parameters are identical to the transmit side.

## Interface
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line bit rate.
- `CLKS_PER_BIT` (derived, not overridable): CLK_FREQ / BAUD_RATE, integer division; 5208 at defaults. HALF_BIT = CLKS_PER_BIT / 2 (2604).
- `clk` input, 1 bit: single clock, rising-edge.
- `reset` input, 1 bit: reset is synchronous and active-high.
- `rx` input, 1 bit: asynchronous serial line; idles high.
- `data` output, 8 bits: last correctly framed byte; held until the next good frame.
- `data_valid` output, 1 bit: one-cycle pulse when `data` updates.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1. All FSM decisions use the synchronised signal `rx_s`.
- Counters:
  - `clk_cnt` is wide enough for CLKS_PER_BIT-1; it clears on every state change.
  - `bit_idx` is 3 bits.
- FSM states:
  - IDLE: when `rx_s` is 0, go to START and set `clk_cnt` to 0.
  - START: when `clk_cnt` reaches HALF_BIT-1 and `rx_s` is 0, go to DATA with `bit_idx` = 0. If `rx_s` is 1 at that point, treat it as a glitch and return to IDLE with no output pulse.
  - DATA: when `clk_cnt` reaches CLKS_PER_BIT-1, write `rx_s` into shift-register bit `bit_idx` (LSB first). After bit 7, go to STOP.
  - STOP: when `clk_cnt` reaches CLKS_PER_BIT-1, sample the stop bit.
    - If `rx_s` is 1: load `data` from the shift register, pulse `data_valid`, go to IDLE.
    - If `rx_s` is 0: pulse `frame_err`, leave `data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` is 1, then go to IDLE. This prevents a break condition (line held low) from retriggering frames.
- `data_valid` and `frame_err` are never high in the same cycle.
- Reset values: `data` 8'h00, `data_valid` 0, `frame_err` 0, `busy` 0, state IDLE, counters 0.
- Reset mid-frame aborts the frame: no pulse, `data` cleared to 0.
- Elaboration check: CLKS_PER_BIT must be at least 4, otherwise report a fatal error.

## Timing
- Synchroniser latency: 2 cycles.
- Let edge k be the first clock edge that samples `rx` low:
  - Edge k+2: FSM enters START.
  - Edge k+2+HALF_BIT: start-bit decision.
  - Edge k+2+HALF_BIT+n·CLKS_PER_BIT: data bit n-1 sampled, for n = 1..8.
  - Edge k+2+HALF_BIT+9·CLKS_PER_BIT: stop bit sampled. `data_valid` or `frame_err` is high for exactly the following cycle, and `data` is valid in that same cycle.
  - At defaults, the stop-bit sample is at edge k+49478.
- `busy` rises at edge k+2.
  - Good frame: `busy` falls at the stop-sample edge.
  - Framing error: `busy` falls one edge after `rx_s` returns high.
- Back-to-back frames: a new start bit is accepted on the first cycle after returning to IDLE. Because the stop bit is sampled at mid-bit, a start edge that arrives up to HALF_BIT cycles early is not lost.
- Pulses are level-free: no acknowledge. The consumer must capture `data` on `data_valid`.

## Structure
- Shared package `uart_pkg`:
  - function `clks_per_bit(clk_freq, baud_rate)`.
  - state enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - constants DATA_BITS = 8 and the idle line level (1).
  - The transmitter imports the same package.
- One sub-module, `uart_sync`: a 2-flop synchroniser with a reset value parameter. It is reused for any other asynchronous inputs, such as switches.
- The FSM, counters and shift register stay in `uart_rx`.

## Test plan
Benches use CLK_FREQ=160 and BAUD_RATE=10 (CLKS_PER_BIT=16, HALF_BIT=8) unless stated otherwise.
- Single frame: send 0xA5 as 8N1 → one `data_valid` pulse, `data` = 8'hA5, `frame_err` stays 0, pulse at edge k+2+8+144 after the start edge.
- Back-to-back frames: send 0x00, 0xFF, 0x55 with no idle gap → three `data_valid` pulses in order with matching `data`, 160 cycles apart.
- Glitch rejection: low pulse of 5 cycles on `rx` → `busy` high for about 8 cycles, then IDLE, with no `data_valid`, no `frame_err`, and `data` unchanged.
- Framing error: send 0x3C with the stop bit low, then hold the line low for 64 cycles → one `frame_err` pulse, `data` keeps its prior value, `busy` stays high until the line rises, and no new frame starts during the low period.
- Reset mid-frame: assert `reset` for 1 cycle during data bit 4 of 0x81 → all outputs 0 the next cycle, no pulse. A subsequent 0x81 frame is received correctly.
- Defaults sanity: run 50 MHz / 9600 with one 0x01 frame → `data_valid` at edge k+49478, `data` = 8'h01.
